// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin responder for the CDB require/accept handshake.
// Takes one result per cycle from the requesting units and drives it onto the
// registered broadcast bus (BCEN/BClabel/BCdata).
// Optional build macro: CDB_FIXED_PRIO_EN selects legacy fixed priority (unit 0 highest).
module cdb_arbiter #(
    parameter int unsigned N_SRC   = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LABEL_W = 4
) (
    input  logic                       clk,
    input  logic                       RST,
    input  logic [N_SRC-1:0]           require,
    input  logic [N_SRC*DATA_W-1:0]    dataIn,
    input  logic [N_SRC*LABEL_W-1:0]   labelIn,
    output logic [N_SRC-1:0]           requireAC,
    output logic                       BCEN,
    output logic [LABEL_W-1:0]         BClabel,
    output logic [DATA_W-1:0]          BCdata,
    output logic [$clog2(N_SRC)-1:0]   ptr
);

    localparam int unsigned PTR_W = $clog2(N_SRC);

    logic [N_SRC-1:0]   elig;
    logic               grant_found;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   cand_idx;
    logic               grant;

    logic               bcen_q;
    logic [LABEL_W-1:0] bclabel_q, bclabel_d;
    logic [DATA_W-1:0]  bcdata_q, bcdata_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;

    // A request with tag 0 has no producer and is never eligible
    always_comb begin
        elig = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            elig[i] = require[i] && (labelIn[i*LABEL_W +: LABEL_W] != '0);
        end
    end

    // Search eligible sources from ptr upward, wrapping; first hit wins
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int off = 0; off < int'(N_SRC); off++) begin
            cand_idx = PTR_W'((int'(ptr_q) + off) % int'(N_SRC));
            if (!grant_found && elig[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign grant = grant_found && !RST;

    // One-hot accept, suppressed while reset is held
    always_comb begin
        requireAC = '0;
        if (grant) begin
            requireAC[grant_idx] = 1'b1;
        end
    end

    // Next broadcast payload and pointer; payload holds when nothing is granted
    always_comb begin
        bclabel_d = bclabel_q;
        bcdata_d  = bcdata_q;
        ptr_d     = ptr_q;
        if (grant) begin
            bclabel_d = labelIn[int'(grant_idx)*LABEL_W +: LABEL_W];
            bcdata_d  = dataIn[int'(grant_idx)*DATA_W +: DATA_W];
`ifdef CDB_FIXED_PRIO_EN
            ptr_d     = '0;
`else
            ptr_d     = (int'(grant_idx) == int'(N_SRC) - 1) ? '0 : grant_idx + PTR_W'(1);
`endif
        end
    end

    // Broadcast and pointer registers
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            bcen_q    <= 1'b0;
            bclabel_q <= '0;
            bcdata_q  <= '0;
            ptr_q     <= '0;
        end else begin
            bcen_q    <= grant;
            bclabel_q <= bclabel_d;
            bcdata_q  <= bcdata_d;
            ptr_q     <= ptr_d;
        end
    end

    assign BCEN    = bcen_q;
    assign BClabel = bclabel_q;
    assign BCdata  = bcdata_q;
    assign ptr     = ptr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (default round-robin build;
// fixed-priority expectations apply when CDB_FIXED_PRIO_EN is defined).
module tb_cdb_arbiter;

    localparam int unsigned N_SRC   = 4;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned LABEL_W = 4;
`ifdef CDB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic                      clk;
    logic                      RST;
    logic [N_SRC-1:0]          require;
    logic [N_SRC*DATA_W-1:0]   dataIn;
    logic [N_SRC*LABEL_W-1:0]  labelIn;
    logic [N_SRC-1:0]          requireAC;
    logic                      BCEN;
    logic [LABEL_W-1:0]        BClabel;
    logic [DATA_W-1:0]         BCdata;
    logic [1:0]                ptr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] dvals [N_SRC];

    cdb_arbiter #(.N_SRC(N_SRC), .DATA_W(DATA_W), .LABEL_W(LABEL_W)) dut (
        .clk       (clk),
        .RST       (RST),
        .require   (require),
        .dataIn    (dataIn),
        .labelIn   (labelIn),
        .requireAC (requireAC),
        .BCEN      (BCEN),
        .BClabel   (BClabel),
        .BCdata    (BCdata),
        .ptr       (ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic req, input logic [LABEL_W-1:0] lbl,
                           input logic [DATA_W-1:0] dat);
        require[i] = req;
        labelIn[i*LABEL_W +: LABEL_W] = lbl;
        dataIn[i*DATA_W +: DATA_W] = dat;
    endtask

    task automatic load_all();
        for (int i = 0; i < int'(N_SRC); i++) set_src(i, 1'b1, LABEL_W'(i + 1), dvals[i]);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        load_all();
        #1;
        n_checks++; if (requireAC !== 4'b0000) begin n_fail++; $display("FAIL reset_ac got=%b exp=0000", requireAC); end
        n_checks++; if (BCEN !== 1'b0) begin n_fail++; $display("FAIL reset_bcen got=%b exp=0", BCEN); end
        n_checks++; if (ptr !== 2'd0) begin n_fail++; $display("FAIL reset_ptr got=%0d exp=0", ptr); end
        n_checks++; if (BClabel !== 4'h0 || BCdata !== 32'h0) begin n_fail++; $display("FAIL reset_bus got=%h/%h exp=0/0", BClabel, BCdata); end
        tick();
        RST = 1'b0;
        #1;
        n_checks++; if (requireAC !== 4'b0001) begin n_fail++; $display("FAIL release_ac got=%b exp=0001", requireAC); end
        tick();
        n_checks++; if (BCEN !== 1'b1 || BClabel !== 4'h1 || BCdata !== dvals[0]) begin
            n_fail++; $display("FAIL release_bc got=%b/%h/%h exp=1/1/%h", BCEN, BClabel, BCdata, dvals[0]); end
        n_checks++; if (ptr !== (FIXED ? 2'd0 : 2'd1)) begin n_fail++; $display("FAIL release_ptr got=%0d exp=%0d", ptr, FIXED ? 0 : 1); end
        require = '0;
        tick();
        n_checks++; if (BCEN !== 1'b0 || BClabel !== 4'h1) begin n_fail++; $display("FAIL idle_hold got=%b/%h exp=0/1", BCEN, BClabel); end
    endtask

    task automatic test_single();
        set_src(1, 1'b1, 4'h5, 32'hDEADBEEF);
        #1;
        n_checks++; if (requireAC !== 4'b0010) begin n_fail++; $display("FAIL single_ac got=%b exp=0010", requireAC); end
        tick();
        n_checks++; if (BCEN !== 1'b1 || BClabel !== 4'h5 || BCdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL single_bc got=%b/%h/%h exp=1/5/deadbeef", BCEN, BClabel, BCdata); end
        n_checks++; if (ptr !== (FIXED ? 2'd0 : 2'd2)) begin n_fail++; $display("FAIL single_ptr got=%0d exp=%0d", ptr, FIXED ? 0 : 2); end
        require = '0;
        tick();
        n_checks++; if (BCEN !== 1'b0 || BClabel !== 4'h5 || BCdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL single_hold got=%b/%h/%h exp=0/5/deadbeef", BCEN, BClabel, BCdata); end
    endtask

    task automatic test_contention();
        int g;
        RST = 1'b1;
        #2;
        RST = 1'b0;
        load_all();
        for (int k = 0; k < 5; k++) begin
            g = FIXED ? 0 : (k % int'(N_SRC));
            #1;
            n_checks++; if (requireAC !== 4'(1 << g)) begin n_fail++; $display("FAIL cont_ac[%0d] got=%b exp=%b", k, requireAC, 4'(1 << g)); end
            tick();
            n_checks++; if (BCEN !== 1'b1 || BClabel !== 4'(g + 1) || BCdata !== dvals[g]) begin
                n_fail++; $display("FAIL cont_bc[%0d] got=%b/%h/%h exp=1/%h/%h", k, BCEN, BClabel, BCdata, 4'(g + 1), dvals[g]); end
            n_checks++; if (ptr !== (FIXED ? 2'd0 : 2'((g + 1) % int'(N_SRC)))) begin
                n_fail++; $display("FAIL cont_ptr[%0d] got=%0d exp=%0d", k, ptr, FIXED ? 0 : (g + 1) % int'(N_SRC)); end
        end
        require = '0;
        tick();
    endtask

`ifndef CDB_FIXED_PRIO_EN
    // Pointer is 1 on entry; move it to 3, then check the 3 -> 0 wrap
    task automatic test_wrap();
        set_src(2, 1'b1, 4'h3, dvals[2]);
        tick();
        n_checks++; if (ptr !== 2'd3) begin n_fail++; $display("FAIL wrap_setup_ptr got=%0d exp=3", ptr); end
        require = 4'b1001;
        #1;
        n_checks++; if (requireAC !== 4'b1000) begin n_fail++; $display("FAIL wrap_ac3 got=%b exp=1000", requireAC); end
        tick();
        n_checks++; if (BClabel !== 4'h4 || ptr !== 2'd0) begin n_fail++; $display("FAIL wrap_g3 got=%h/%0d exp=4/0", BClabel, ptr); end
        n_checks++; if (requireAC !== 4'b0001) begin n_fail++; $display("FAIL wrap_ac0 got=%b exp=0001", requireAC); end
        tick();
        n_checks++; if (BCEN !== 1'b1 || BClabel !== 4'h1 || ptr !== 2'd1) begin
            n_fail++; $display("FAIL wrap_g0 got=%b/%h/%0d exp=1/1/1", BCEN, BClabel, ptr); end
        require = '0;
    endtask

    // Pointer is 1 on entry
    task automatic test_tag_zero();
        set_src(0, 1'b1, 4'h0, 32'h1234_5678);
        #1;
        n_checks++; if (requireAC !== 4'b0000) begin n_fail++; $display("FAIL tag0_ac got=%b exp=0000", requireAC); end
        tick();
        n_checks++; if (BCEN !== 1'b0 || ptr !== 2'd1 || BClabel !== 4'h1) begin
            n_fail++; $display("FAIL tag0_bc got=%b/%0d/%h exp=0/1/1", BCEN, ptr, BClabel); end
        set_src(2, 1'b1, 4'h9, 32'hCAFE_0002);
        #1;
        n_checks++; if (requireAC !== 4'b0100) begin n_fail++; $display("FAIL tag0_mix_ac got=%b exp=0100", requireAC); end
        tick();
        n_checks++; if (BCEN !== 1'b1 || BClabel !== 4'h9 || BCdata !== 32'hCAFE_0002 || ptr !== 2'd3) begin
            n_fail++; $display("FAIL tag0_mix_bc got=%b/%h/%h/%0d exp=1/9/cafe0002/3", BCEN, BClabel, BCdata, ptr); end
        require = '0;
    endtask

    // Pointer is 3 on entry; reset lands while a broadcast is on the bus
    task automatic test_reset_mid();
        load_all();
        tick();
        n_checks++; if (BCEN !== 1'b1 || BClabel !== 4'h4 || ptr !== 2'd0) begin
            n_fail++; $display("FAIL rmid_pre got=%b/%h/%0d exp=1/4/0", BCEN, BClabel, ptr); end
        tick();
        n_checks++; if (ptr !== 2'd1) begin n_fail++; $display("FAIL rmid_ptr1 got=%0d exp=1", ptr); end
        #2;
        RST = 1'b1;
        #1;
        n_checks++; if (BCEN !== 1'b0 || ptr !== 2'd0 || requireAC !== 4'b0000) begin
            n_fail++; $display("FAIL rmid_async got=%b/%0d/%b exp=0/0/0000", BCEN, ptr, requireAC); end
        tick();
        RST = 1'b0;
        #1;
        n_checks++; if (requireAC !== 4'b0001) begin n_fail++; $display("FAIL rmid_rearb got=%b exp=0001", requireAC); end
        tick();
        n_checks++; if (BCEN !== 1'b1 || BClabel !== 4'h1) begin n_fail++; $display("FAIL rmid_bc got=%b/%h exp=1/1", BCEN, BClabel); end
        require = '0;
    endtask
`endif

    initial begin
        dvals[0] = 32'hA000_0000;
        dvals[1] = 32'hB111_1111;
        dvals[2] = 32'hC222_2222;
        dvals[3] = 32'hD333_3333;
        RST = 1'b1;
        require = '0;
        dataIn = '0;
        labelIn = '0;
        #3;
        test_reset();
        test_single();
        test_contention();
`ifndef CDB_FIXED_PRIO_EN
        test_wrap();
        test_tag_zero();
        test_reset_mid();
`endif
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
